// File: rtl/scroll_sequencer_if.sv
// scroll_sequencer_if: timing, configuration and scroll outputs for scroll_sequencer.
//   master : drives vsync, cfg_speed, cfg_div, cfg_dir, pause and step_req;
//            observes offset_x, pattern_sel, frame_tick and state
//   slave  : the sequencer itself (the directions are reversed)
interface scroll_sequencer_if;
   logic       vsync;
   logic [3:0] cfg_speed;
   logic [3:0] cfg_div;
   logic       cfg_dir;
   logic       pause;
   logic       step_req;
   logic [9:0] offset_x;
   logic [1:0] pattern_sel;
   logic       frame_tick;
   logic [1:0] state;

   modport master (
      output vsync, cfg_speed, cfg_div, cfg_dir, pause, step_req,
      input  offset_x, pattern_sel, frame_tick, state
   );

   modport slave (
      input  vsync, cfg_speed, cfg_div, cfg_dir, pause, step_req,
      output offset_x, pattern_sel, frame_tick, state
   );
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: once per video frame, steps a horizontal scroll offset and
// cycles a colour-pattern index. All visible state changes on frame events only,
// so the image never tears mid-frame.
//   clk, rst_n (asynchronous, active-low)
//   bus.vsync                     sync from the timing generator
//   bus.cfg_speed/cfg_div/cfg_dir step size, frame divider and direction
//   bus.pause, bus.step_req       hold the sequence / single-step while held
//   bus.offset_x, bus.pattern_sel scroll offset and active pattern
//   bus.frame_tick, bus.state     frame pulse and FSM state (SYNC/RUN/PAUSE/STEP)
module scroll_sequencer #(
   parameter logic        VSYNC_ACTIVE   = 1'b0,
   parameter int unsigned PATTERN_FRAMES = 240
) (
   input logic               clk,
   input logic               rst_n,
   scroll_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      STEP  = 2'd3
   } state_t;

   localparam logic       VSYNC_IDLE = ~VSYNC_ACTIVE;
   localparam logic [7:0] PAT_LAST   = 8'(PATTERN_FRAMES - 1);

   state_t     state_q, state_d;
   logic       vsync_q;
   logic       armed_q;
   logic       frame_ev;
   logic       tick_q, tick_d;
   logic [9:0] offset_q, offset_d;
   logic [1:0] pat_sel_q, pat_sel_d;
   logic [3:0] div_cnt_q, div_cnt_d;
   logic [7:0] pat_cnt_q, pat_cnt_d;
   logic [9:0] stepped;

   // armed_q blocks the first cycle after reset release, so a vsync already
   // active at release is not mistaken for an edge against the reset value
   // of vsync_q.
   assign frame_ev = armed_q && (bus.vsync == VSYNC_ACTIVE) && (vsync_q == VSYNC_IDLE);

   // 10-bit arithmetic wraps modulo 1024 in both directions.
   assign stepped = bus.cfg_dir ? (offset_q - {6'd0, bus.cfg_speed})
                                : (offset_q + {6'd0, bus.cfg_speed});

   always_comb begin
      state_d   = state_q;
      offset_d  = offset_q;
      pat_sel_d = pat_sel_q;
      div_cnt_d = div_cnt_q;
      pat_cnt_d = pat_cnt_q;
      tick_d    = frame_ev && (state_q != SYNC);

      unique case (state_q)
         SYNC: begin
            if (frame_ev) begin
               state_d = bus.pause ? PAUSE : RUN;
            end
         end
         RUN: begin
            // pause is checked every cycle and takes priority over a
            // coincident frame event.
            if (bus.pause) begin
               state_d = PAUSE;
            end else if (frame_ev) begin
               if (div_cnt_q == bus.cfg_div) begin
                  div_cnt_d = '0;
                  offset_d  = stepped;
                  if (pat_cnt_q == PAT_LAST) begin
                     pat_cnt_d = '0;
                     pat_sel_d = pat_sel_q + 2'd1;
                  end else begin
                     pat_cnt_d = pat_cnt_q + 8'd1;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 4'd1;
               end
            end
         end
         PAUSE: begin
            if (!bus.pause) begin
               state_d = RUN;
            end else if (bus.step_req) begin
               state_d = STEP;
            end
         end
         STEP: begin
            // Single step moves only the offset; divider and pattern counters hold.
            if (frame_ev) begin
               offset_d = stepped;
               state_d  = bus.pause ? PAUSE : RUN;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SYNC;
         vsync_q   <= VSYNC_IDLE;
         armed_q   <= 1'b0;
         tick_q    <= 1'b0;
         offset_q  <= '0;
         pat_sel_q <= '0;
         div_cnt_q <= '0;
         pat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         vsync_q   <= bus.vsync;
         armed_q   <= 1'b1;
         tick_q    <= tick_d;
         offset_q  <= offset_d;
         pat_sel_q <= pat_sel_d;
         div_cnt_q <= div_cnt_d;
         pat_cnt_q <= pat_cnt_d;
      end
   end

   assign bus.offset_x    = offset_q;
   assign bus.pattern_sel = pat_sel_q;
   assign bus.frame_tick  = tick_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed scenarios for scroll_sequencer, checked every
// cycle against a frame-level reference model plus literal expectations.
module tb_scroll_sequencer;

   localparam int  PF    = 4;
   localparam bit  ACT   = 1'b0;
   localparam bit  INACT = 1'b1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   scroll_sequencer_if bif ();

   scroll_sequencer #(
      .VSYNC_ACTIVE   (1'b0),
      .PATTERN_FRAMES (PF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;

   // Reference model: state codes 0=SYNC 1=RUN 2=PAUSE 3=STEP.
   int m_off, m_pat, m_pc, m_dc, m_st, m_tick;
   bit m_vq, m_arm;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_off = 0; m_pat = 0; m_pc = 0; m_dc = 0; m_st = 0; m_tick = 0;
      m_vq = INACT; m_arm = 0;
   endtask

   // A move shifts the offset by cfg_speed modulo 1024; stepped frames counted
   // in RUN advance the pattern after every PF of them.
   task automatic model_move(input bit counts_frame);
      if (bif.cfg_dir) m_off = (m_off + 1024 - int'(bif.cfg_speed)) % 1024;
      else             m_off = (m_off + int'(bif.cfg_speed)) % 1024;
      if (counts_frame) begin
         m_pc = m_pc + 1;
         if (m_pc == PF) begin
            m_pc  = 0;
            m_pat = (m_pat + 1) % 4;
         end
      end
   endtask

   initial begin
      bit ev;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            ev     = m_arm && (bif.vsync == ACT) && (m_vq != ACT);
            m_vq   = bif.vsync;
            m_arm  = 1;
            m_tick = (ev && m_st != 0) ? 1 : 0;
            if (m_st == 0) begin
               if (ev) m_st = bif.pause ? 2 : 1;
            end else if (m_st == 1) begin
               if (bif.pause) m_st = 2;
               else if (ev) begin
                  if (m_dc == int'(bif.cfg_div)) begin
                     m_dc = 0;
                     model_move(1);
                  end else m_dc = m_dc + 1;
               end
            end else if (m_st == 2) begin
               if (!bif.pause) m_st = 1;
               else if (bif.step_req) m_st = 3;
            end else begin
               if (ev) begin
                  model_move(0);
                  m_st = bif.pause ? 2 : 1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check("offset_x",    int'(bif.offset_x),    m_off);
         check("pattern_sel", int'(bif.pattern_sel), m_pat);
         check("frame_tick",  int'(bif.frame_tick),  m_tick);
         check("state",       int'(bif.state),       m_st);
         if (bif.frame_tick) tick_cnt++;
      end
   end

   task automatic frame();
      @(negedge clk); bif.vsync = ACT;
      repeat (2) @(negedge clk);
      bif.vsync = INACT;
      repeat (5) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic set_cfg(input int sp, input int dv, input bit dr);
      bif.cfg_speed = 4'(sp);
      bif.cfg_div   = 4'(dv);
      bif.cfg_dir   = dr;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int t0;
      bif.vsync = INACT; bif.pause = 1'b0; bif.step_req = 1'b0;
      set_cfg(2, 0, 0);

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_offset", int'(bif.offset_x), 0);
      check("rst_state",  int'(bif.state),    0);
      check("rst_tick",   int'(bif.frame_tick), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic run: SYNC exit, then 2,4,6,8
      t0 = tick_cnt;
      frame();
      check("basic_sync_exit", int'(bif.offset_x), 0);
      check("basic_state_run", int'(bif.state), 1);
      frames(4);
      check("basic_offset", int'(bif.offset_x), 8);
      check("basic_pattern", int'(bif.pattern_sel), 1);
      check("basic_ticks", tick_cnt - t0, 4);

      // Divider and wrap: decrement 15 every 3rd frame
      do_reset();
      set_cfg(15, 2, 1);
      frame();
      frames(2);
      check("div_no_step", int'(bif.offset_x), 0);
      frame();
      check("div_wrap1", int'(bif.offset_x), 1009);
      frames(3);
      check("div_wrap2", int'(bif.offset_x), 994);

      // Pattern advance: PF=4, one step per frame
      do_reset();
      set_cfg(1, 0, 0);
      frame();
      frames(4);
      check("pat_step4", int'(bif.pattern_sel), 1);
      frames(13);
      check("pat_step17_sel", int'(bif.pattern_sel), 0);
      check("pat_step17_off", int'(bif.offset_x), 17);

      // Pause coincident with a frame event, then single step
      @(negedge clk); bif.vsync = ACT; bif.pause = 1'b1;
      repeat (2) @(negedge clk); bif.vsync = INACT;
      repeat (3) @(negedge clk);
      check("pause_no_step", int'(bif.offset_x), 17);
      check("pause_state", int'(bif.state), 2);
      bif.step_req = 1'b1; @(negedge clk); bif.step_req = 1'b0;
      check("step_state", int'(bif.state), 3);
      @(negedge clk);
      bif.step_req = 1'b1; @(negedge clk); bif.step_req = 1'b0;
      frame();
      check("step_offset", int'(bif.offset_x), 18);
      check("step_back_pause", int'(bif.state), 2);
      check("step_pattern", int'(bif.pattern_sel), 0);
      frame();
      check("step_dropped", int'(bif.offset_x), 18);
      bif.pause = 1'b0; @(negedge clk);
      check("unpause_run", int'(bif.state), 1);

      // Config sampling only on frame events
      bif.cfg_speed = 4'd3;
      frame();
      check("cfg_speed3", int'(bif.offset_x), 21);
      repeat (2) @(negedge clk); bif.cfg_speed = 4'd7;
      frame();
      check("cfg_speed7", int'(bif.offset_x), 28);
      repeat (2) @(negedge clk); bif.cfg_speed = 4'd15;
      repeat (2) @(negedge clk); bif.cfg_speed = 4'd7;
      frame();
      check("cfg_restored", int'(bif.offset_x), 35);

      // Asynchronous reset mid-frame at offset 100
      do_reset();
      set_cfg(10, 0, 0);
      frames(11);
      check("pre_reset_offset", int'(bif.offset_x), 100);
      @(negedge clk); bif.vsync = ACT;
      @(posedge clk); #3; rst_n = 1'b0; #1;
      check("async_offset", int'(bif.offset_x), 0);
      check("async_state",  int'(bif.state), 0);
      check("async_pattern", int'(bif.pattern_sel), 0);
      check("async_tick",   int'(bif.frame_tick), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("release_active_no_event", int'(bif.state), 0);
      bif.vsync = INACT;
      repeat (3) @(negedge clk);
      frame();
      check("release_sync_exit_state", int'(bif.state), 1);
      check("release_sync_exit_off", int'(bif.offset_x), 0);
      frame();
      check("release_first_step", int'(bif.offset_x), 10);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 Parameter VSYNC_ACTIVE, default 0, SHALL give the vsync level that marks the sync pulse (0 = active-low).
REQ-002 Parameter PATTERN_FRAMES, default 240, range 1..256, SHALL give the number of stepped frames per pattern.
REQ-003 clk  input  1  SHALL be the pixel clock; every flop is on its rising edge, and vsync is synchronous to it.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 vsync  input  1  SHALL be the sync output of the timing generator.
REQ-006 cfg_speed  input  4  SHALL be the pixels added to or subtracted from offset_x per step; 0 = no motion.
REQ-007 cfg_div  input  4  SHALL set the step rate: one step every cfg_div+1 frames.
REQ-008 cfg_dir  input  1  SHALL select direction: 0 = increment offset_x, 1 = decrement.
REQ-009 pause  input  1  SHALL be a level; while it is high the block holds in PAUSE.
REQ-010 step_req  input  1  SHALL be a one-cycle pulse requesting a single step while paused.
REQ-011 offset_x  output  10  SHALL be the horizontal scroll offset, added by the pixel datapath.
REQ-012 pattern_sel  output  2  SHALL be the active colour-pattern index.
REQ-013 frame_tick  output  1  SHALL be a one-cycle pulse marking each frame event.
REQ-014 state  output  2  SHALL report the FSM state: SYNC=0, RUN=1, PAUSE=2, STEP=3.

Function
REQ-015 A frame event SHALL occur on the clk cycle where vsync goes from inactive to VSYNC_ACTIVE, detected with one registered copy of vsync.
REQ-016 frame_tick SHALL be asserted exactly one cycle after the sampled edge.
REQ-017 offset_x, pattern_sel and all internal counters SHALL change only on frame-event cycles; the image never tears mid-frame.
REQ-018 cfg_speed, cfg_div and cfg_dir SHALL be sampled only on frame-event cycles; changes between events have no effect.
REQ-019 SYNC SHALL be the reset state and SHALL go to RUN, or to PAUSE if pause is high, on the first frame event; no step occurs on that event.
REQ-020 In RUN, each frame event SHALL do the following:
- if div_cnt == cfg_div: take a step and clear div_cnt;
- otherwise: increment div_cnt.
REQ-021 A step SHALL update offset_x to offset_x + cfg_speed (cfg_dir=0) or offset_x - cfg_speed (cfg_dir=1), both modulo 1024, so 1020+8 = 4 and 3-8 = 1019.
REQ-022 Each RUN step SHALL increment pat_cnt. When pat_cnt reaches PATTERN_FRAMES-1, the step SHALL clear pat_cnt and advance pattern_sel modulo 4 (3 -> 0).
REQ-023 RUN SHALL go to PAUSE when pause is high; the check happens on every cycle, not only on frame events.
REQ-024 If pause and a frame event coincide in RUN, pause SHALL win: no step, no counter change, and the next state is PAUSE.
REQ-025 In PAUSE, offset_x, pattern_sel, div_cnt and pat_cnt SHALL hold.
REQ-026 PAUSE SHALL go to RUN the cycle after pause falls, with div_cnt unchanged.
REQ-027 In PAUSE, a step_req pulse SHALL move the FSM to STEP.
REQ-028 STEP SHALL wait for the next frame event, apply exactly one offset_x step (ignoring div_cnt, leaving pat_cnt and pattern_sel unchanged), and then return to PAUSE, or to RUN if pause is low by then.
REQ-029 step_req SHALL be ignored in SYNC, RUN and STEP; pulses arriving while in STEP are not queued.
REQ-030 frame_tick SHALL pulse on every frame event in every state except SYNC.

Reset
REQ-031 While rst_n is low, the outputs SHALL be: offset_x=0, pattern_sel=0, frame_tick=0, state=SYNC.
REQ-032 While rst_n is low, the internal state SHALL be: div_cnt=0, pat_cnt=0, registered vsync = inactive level.
REQ-033 Reset asserted mid-frame or in any state SHALL clear everything immediately, with no frame-event handling on the reset-release cycle.
REQ-034 After release, the first vsync edge SHALL only leave SYNC (REQ-019); a vsync level already active at release SHALL NOT count as an edge.

Verification
REQ-035 Scenario "basic run": speed=2, div=0, dir=0, pause=0, 5 frames -> offset_x = 0,0(SYNC exit),2,4,6,8; frame_tick once per frame.
REQ-036 Scenario "divider and wrap": speed=15, div=2, dir=1, 7 frames after SYNC exit -> steps on frames 3 and 6 only; offset_x = 1009 then 994.
REQ-037 Scenario "pattern advance": PATTERN_FRAMES=4, speed=1, div=0, 17 frames after SYNC exit -> pattern_sel sequence 1,2,3,0 at steps 4,8,12,16.
REQ-038 Scenario "pause and single step": pause rises coincident with a frame event -> no step, state=PAUSE; step_req -> state=STEP, exactly +speed at next event, back to PAUSE; second step_req during STEP is dropped.
REQ-039 Scenario "config sampling": cfg_speed changed 3->7 mid-frame -> next step uses 7; changed and restored between two events -> no effect.
REQ-040 Scenario "async reset": rst_n pulsed low mid-frame in RUN with offset_x=100 -> outputs zero immediately, state=SYNC; vsync held active at release causes no event.
